// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
// Digit codes are packed as {neg, one, two} select bits.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] ZERO = 3'b000;
  localparam logic [2:0] P1   = 3'b010;
  localparam logic [2:0] P2   = 3'b001;
  localparam logic [2:0] M1   = 3'b110;
  localparam logic [2:0] M2   = 3'b101;

  function automatic int ndig(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Modified-Booth recoder: maps one overlapping multiplier triplet to
// negate / select-one / select-two controls for the partial product.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] i_triplet,
  output logic       o_neg,
  output logic       o_one,
  output logic       o_two
);

  logic [2:0] w_code;

  always_comb begin
    w_code = ZERO;
    case (i_triplet)
      3'b001, 3'b010: w_code = P1;
      3'b011:         w_code = P2;
      3'b100:         w_code = M2;
      3'b101, 3'b110: w_code = M1;
      default:        w_code = ZERO;
    endcase
  end

  assign {o_neg, o_one, o_two} = w_code;

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier, one recoded digit per clock,
// signed or unsigned per transaction, valid/ready on both sides.
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int NDIG = ndig(WIDTH);
  localparam int AW   = 2 * WIDTH + 2;
  localparam int BW   = WIDTH + 3;
  localparam int CW   = $clog2(NDIG);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_acc;
  // Multiplicand pre-shifted by 2k each digit, so no barrel shifter is needed.
  logic [AW-1:0] r_a;
  // Multiplier with the implicit b[-1]=0 appended; shifted right by 2 each digit.
  logic [BW-1:0] r_b;

  logic          w_neg;
  logic          w_one;
  logic          w_two;
  logic [AW-1:0] w_mag;
  logic [AW-1:0] w_pp;
  logic          w_last;

  booth_r4_encoder u_enc (
    .i_triplet (r_b[2:0]),
    .o_neg     (w_neg),
    .o_one     (w_one),
    .o_two     (w_two)
  );

  assign w_last = (r_cnt == CW'(NDIG - 1));

  always_comb begin
    w_mag = '0;
    if (w_two)      w_mag = r_a << 1;
    else if (w_one) w_mag = r_a;
    w_pp = w_neg ? (~w_mag + AW'(1)) : w_mag;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = CALC;
      end
      CALC: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= {{(AW - WIDTH){in_signed & in_a[WIDTH-1]}}, in_a};
            r_b   <= {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        CALC: begin
          r_acc <= r_acc + w_pp;
          r_a   <= r_a << 2;
          r_b   <= r_b >> 2;
          r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Top two accumulator bits are only sign/carry extension and are dropped.
  assign out_p = (r_state == DONE) ? r_acc[2*WIDTH-1:0] : '0;

endmodule
